// File: rtl/master_port.sv
// Serial bus initiator: takes one parallel read/write request and runs it LSB-first on the serial bus.
// Latency: write completes (ddone) 2+ADDR_WIDTH+DATA_WIDTH cycles after accept when the slave is ready.
// Backpressure: waits on sready and svalid; a stall of TIMEOUT idle cycles aborts with derr.
module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dreq,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  derr,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid,
  input  logic                  sready
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int SW   = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_SLV, ADDR, WDATA, RWAIT, RDATA, DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [SW-1:0]         tx_q, tx_d;       // {wdata, addr}, popped from bit 0
  logic [DATA_WIDTH-1:0] rx_q, rx_d;       // read bits shift in from the top
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic                  mwdata_q, mwdata_d;
  logic                  mmode_q, mmode_d;
  logic                  mvalid_q, mvalid_d;
  logic                  ddone_q, ddone_d;
  logic                  derr_q, derr_d;
  logic                  abort;
  logic                  burst;

  // Idle indication is the only combinational output, so it reads 1 throughout reset.
  assign dready = (state_q == IDLE);
  assign drdata = drdata_q;
  assign ddone  = ddone_q;
  assign derr   = derr_q;
  assign mwdata = mwdata_q;
  assign mmode  = mmode_q;
  assign mvalid = mvalid_q;

  // Next-state, datapath and registered-output selection.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    drdata_d = drdata_q;
    abort    = 1'b0;

    case (state_q)
      IDLE: begin
        if (dreq) begin
          mode_d  = dmode;
          tx_d    = {dwdata, daddr};
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = WAIT_SLV;
        end
      end
      WAIT_SLV: begin
        if (sready) begin
          cnt_d   = '0;
          state_d = ADDR;
        end else if (tmo_q == TMO_LAST) begin
          abort   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d = '0;
          if (mode_q) begin
            state_d = WDATA;
          end else begin
            tmo_d   = '0;
            rx_d    = '0;
            state_d = RWAIT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WDATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RWAIT, RDATA: begin
        if (svalid) begin
          rx_d    = {srdata, rx_q[DATA_WIDTH-1:1]};
          tmo_d   = '0;
          state_d = RDATA;
          if (cnt_q == DATA_LAST) begin
            drdata_d = {srdata, rx_q[DATA_WIDTH-1:1]};
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          // Partial read bits are dropped; drdata keeps the last good value.
          abort   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they belong to.
    burst    = (state_d == ADDR) || (state_d == WDATA);
    mvalid_d = burst;
    mmode_d  = burst & mode_q;
    mwdata_d = burst & tx_q[0];
    if (burst) begin
      tx_d = {1'b0, tx_q[SW-1:1]};
    end
    ddone_d = (state_d == DONE);
    derr_d  = abort;
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      drdata_q <= '0;
      mwdata_q <= 1'b0;
      mmode_q  <= 1'b0;
      mvalid_q <= 1'b0;
      ddone_q  <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      drdata_q <= drdata_d;
      mwdata_q <= mwdata_d;
      mmode_q  <= mmode_d;
      mvalid_q <= mvalid_d;
      ddone_q  <= ddone_d;
      derr_q   <= derr_d;
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: directed vector table, reset/idle sequences, then random transactions.
// Expected timing and data come from an arithmetic model of the bus protocol.
// The bench drives inputs and samples outputs on the falling clock edge.
module tb_master_port;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          dreq, dmode;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic          dready;
  logic [DW-1:0] drdata;
  logic          ddone, derr, mwdata, mmode, mvalid;
  logic          srdata, svalid, sready;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] model_drd;

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .dreq(dreq), .dmode(dmode), .daddr(daddr), .dwdata(dwdata),
    .dready(dready), .drdata(drdata), .ddone(ddone), .derr(derr),
    .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            dly;      // cycles of sready=0 after entering WAIT_SLV
    int            pre;      // idle cycles before the first read bit
    int            gap_at;   // read bit index after which a gap is inserted (>=DW-1: none)
    int            gap_len;
    logic [DW-1:0] rdata;
    int            exp_done; // cycle of ddone, counted from the accept cycle
    bit            exp_err;
    logic [DW-1:0] exp_drd;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Protocol timing from first principles: cycle 0 accept, cycle 1 first WAIT_SLV cycle.
  function automatic void model(input bit mode, input int dly, input int pre, input int gap_at,
                                input int gap_len, output int done, output bit err,
                                output int start, output int nbits, output int r0);
    int gap;
    r0 = 1 << 20;
    if (dly >= TMO) begin
      done = 1 + TMO; err = 1'b1; start = -1; nbits = 0;
      return;
    end
    start = 2 + dly;
    if (mode) begin
      nbits = AW + DW; done = start + nbits; err = 1'b0;
      return;
    end
    nbits = AW;
    r0    = start + AW;
    if (pre >= TMO) begin
      done = r0 + TMO; err = 1'b1;
      return;
    end
    gap = (gap_at < DW - 1) ? gap_len : 0;
    if (gap >= TMO) begin
      done = r0 + pre + gap_at + 1 + TMO; err = 1'b1;
      return;
    end
    done = r0 + pre + DW + gap;
    err  = 1'b0;
  endfunction

  function automatic vec_t mk(input bit mode, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input int dly, input int pre, input int gap_at, input int gap_len,
                              input logic [DW-1:0] rdata, input int exp_done, input bit exp_err,
                              input logic [DW-1:0] exp_drd);
    vec_t v;
    v.mode = mode; v.addr = addr; v.wdata = wdata; v.dly = dly; v.pre = pre;
    v.gap_at = gap_at; v.gap_len = gap_len; v.rdata = rdata;
    v.exp_done = exp_done; v.exp_err = exp_err; v.exp_drd = exp_drd;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    bit            pat_v[$];
    bit            pat_d[$];
    int            m_done, start, nbits, r0, w, first, got_n, dn, done_c;
    int            mm_bad, rdy_bad, stray_bad;
    bit            m_err, err_at;
    logic [31:0]   got, exp_bits;
    int            idx;

    model(v.mode, v.dly, v.pre, v.gap_at, v.gap_len, m_done, m_err, start, nbits, r0);
    for (int j = 0; j < v.pre; j++) begin pat_v.push_back(1'b0); pat_d.push_back(1'b0); end
    if (v.pre < TMO) begin
      for (int j = 0; j < DW; j++) begin
        pat_v.push_back(1'b1); pat_d.push_back(v.rdata[j]);
        if (j == v.gap_at && j < DW - 1)
          for (int k = 0; k < v.gap_len; k++) begin pat_v.push_back(1'b0); pat_d.push_back(1'b0); end
      end
    end
    exp_bits = '0;
    if (nbits == AW + DW) exp_bits[AW+DW-1:0] = {v.wdata, v.addr};
    else if (nbits == AW) exp_bits[AW-1:0] = v.addr;

    @(negedge clk);
    w = 0;
    while (dready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    check({tag, " idle_before"}, 64'(dready), 64'd1);

    // cycle 0: request
    dreq = 1'b1; dmode = v.mode; daddr = v.addr; dwdata = v.wdata;
    sready = 1'b0; svalid = 1'($urandom); srdata = 1'($urandom);
    first = -1; got_n = 0; got = '0; dn = 0; done_c = -1; err_at = 1'b0;
    mm_bad = 0; rdy_bad = 0; stray_bad = 0;

    for (int c = 1; c <= v.exp_done + 1; c++) begin
      @(negedge clk);
      if (mvalid) begin
        if (first < 0) first = c;
        if (got_n < 32) got[got_n] = mwdata;
        got_n++;
        if (mmode !== v.mode) mm_bad++;
      end else if (mwdata !== 1'b0 || mmode !== 1'b0) begin
        stray_bad++;
      end
      if (ddone) begin dn++; done_c = c; err_at = derr; end
      else if (derr) stray_bad++;
      if (dready !== ((c > v.exp_done) ? 1'b1 : 1'b0)) rdy_bad++;
      if (c == v.exp_done + 1) check({tag, " drdata"}, 64'(drdata), 64'(v.exp_drd));
      // inputs for cycle c; junk requests while busy must be ignored
      dreq   = (c <= v.exp_done) ? 1'($urandom) : 1'b0;
      daddr  = AW'($urandom);
      dwdata = DW'($urandom);
      dmode  = 1'($urandom);
      sready = (c >= 1 + v.dly) && (c <= v.exp_done);
      idx = c - r0;
      if (idx >= 0 && idx < pat_v.size()) begin
        svalid = pat_v[idx]; srdata = pat_d[idx];
      end else begin
        svalid = 1'($urandom); srdata = 1'($urandom);
      end
    end
    dreq = 1'b0; svalid = 1'b0; srdata = 1'b0; sready = 1'b0;

    check({tag, " nbits"},     64'(got_n),   64'(nbits));
    check({tag, " bits"},      64'(got),     64'(exp_bits));
    check({tag, " start"},     64'(first),   64'(start));
    check({tag, " mmode"},     64'(mm_bad),  64'd0);
    check({tag, " ddone_cnt"}, 64'(dn),      64'd1);
    check({tag, " ddone_cyc"}, 64'(done_c),  64'(v.exp_done));
    check({tag, " derr"},      64'(err_at),  64'(v.exp_err));
    check({tag, " stray"},     64'(stray_bad), 64'd0);
    check({tag, " dready"},    64'(rdy_bad), 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int   m_done, start, nbits, r0;
    bit   m_err;
    vec_t v;

    rstn = 1'b0; dreq = 1'b0; dmode = 1'b0; daddr = '0; dwdata = '0;
    srdata = 1'b0; svalid = 1'b0; sready = 1'b0;
    model_drd = '0;

    #12;
    check("rst dready", 64'(dready), 64'd1);
    check("rst mvalid", 64'(mvalid), 64'd0);
    check("rst mwdata", 64'(mwdata), 64'd0);
    check("rst mmode",  64'(mmode),  64'd0);
    check("rst ddone",  64'(ddone),  64'd0);
    check("rst derr",   64'(derr),   64'd0);
    check("rst drdata", 64'(drdata), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    //            mode addr    wdata  dly pre gap gl  rdata  done err drd
    tbl[0] = mk(1, 12'hA5C, 8'h3E,  0,  0, DW, 0, 8'h00, 22, 0, 8'h00);
    tbl[1] = mk(0, 12'h001, 8'h00,  0,  3, DW, 0, 8'hC3, 25, 0, 8'hC3);
    tbl[2] = mk(0, 12'h7F0, 8'h00,  0,  0,  3, 5, 8'h5A, 27, 0, 8'h5A);
    tbl[3] = mk(1, 12'h123, 8'hFF, 16,  0, DW, 0, 8'h00, 17, 1, 8'h5A);
    tbl[4] = mk(1, 12'h456, 8'h81, 15,  0, DW, 0, 8'h00, 37, 0, 8'h5A);
    tbl[5] = mk(0, 12'h0AB, 8'h00,  0, 16, DW, 0, 8'hFF, 30, 1, 8'h5A);
    tbl[6] = mk(0, 12'h3C3, 8'h00,  0, 15, DW, 0, 8'h96, 37, 0, 8'h96);
    tbl[7] = mk(0, 12'hFFF, 8'h00,  0,  0,  0, 15, 8'h01, 37, 0, 8'h01);
    tbl[8] = mk(0, 12'h800, 8'h00,  0,  0,  6, 16, 8'h7E, 37, 1, 8'h01);
    tbl[9] = mk(0, 12'h2B4, 8'h00,  2,  0, DW, 0, 8'hAA, 24, 0, 8'hAA);
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
      model_drd = tbl[i].exp_drd;
    end

    // Spurious svalid while idle must not disturb drdata or start anything.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      svalid = 1'b1; srdata = 1'b1;
    end
    @(negedge clk);
    check("idle_spur drdata", 64'(drdata), 64'(model_drd));
    check("idle_spur dready", 64'(dready), 64'd1);
    check("idle_spur ddone",  64'(ddone),  64'd0);
    svalid = 1'b0; srdata = 1'b0;

    // Reset in the middle of the address burst.
    dreq = 1'b1; dmode = 1'b1; daddr = 12'h5A5; dwdata = 8'h11; sready = 1'b1;
    @(negedge clk); dreq = 1'b0;
    for (int c = 2; c <= 5; c++) @(negedge clk);
    check("midaddr mvalid", 64'(mvalid), 64'd1);
    rstn = 1'b0;
    #1;
    check("rstmid mvalid", 64'(mvalid), 64'd0);
    check("rstmid ddone",  64'(ddone),  64'd0);
    check("rstmid dready", 64'(dready), 64'd1);
    check("rstmid drdata", 64'(drdata), 64'd0);
    model_drd = '0;
    sready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    run_txn(mk(1, 12'h9C1, 8'hB7, 0, 0, DW, 0, 8'h00, 22, 0, 8'h00), "post_rst");

    // Random transactions against the model.
    for (int i = 0; i < 40; i++) begin
      v.mode    = 1'($urandom);
      v.addr    = AW'($urandom);
      v.wdata   = DW'($urandom);
      v.dly     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      v.pre     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 4));
      v.gap_at  = int'($urandom_range(0, DW - 1));
      v.gap_len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 4));
      v.rdata   = DW'($urandom);
      model(v.mode, v.dly, v.pre, v.gap_at, v.gap_len, m_done, m_err, start, nbits, r0);
      v.exp_done = m_done;
      v.exp_err  = m_err;
      v.exp_drd  = (!v.mode && !m_err) ? v.rdata : model_drd;
      run_txn(v, $sformatf("rnd%0d", i));
      model_drd = v.exp_drd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
